vector_sequencer_6801: RTL and testbench

- Interrupt/reset vector controller for the 6801 core.
- Captures reset and interrupt requests and picks one by fixed 6801 priority.
- When the core grants it, takes ownership of the program-counter control mux and loads PC from the vector pair: high byte first, then low byte.
- Sits between the peripheral IRQ lines, the core microsequencer and the program counter's pc_ctrl/data_in path.

---
 rtl/vector_sequencer_6801_pkg.sv | 77 +++++++
 rtl/vector_sequencer_6801_int_priority.sv | 44 ++++
 rtl/vector_sequencer_6801.sv | 168 ++++++++++++++++
 tb/tb_vector_sequencer_6801.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_sequencer_6801_pkg.sv
// Shared 6801 types for the vector sequencer: pc control operations,
// vector source codes, vector offsets, sequencer states and the request
// bundle consumed by the priority encoder.
package vector_sequencer_6801_pkg;

    // Program counter operation selected through the core pc mux.
    typedef enum logic [1:0] {
        latch_pc   = 2'd0,
        pull_hi_pc = 2'd1,
        pull_lo_pc = 2'd2
    } pc_type;

    // Encoded source being serviced, reported on vec_src.
    localparam logic [3:0] SRC_RESET = 4'd0;
    localparam logic [3:0] SRC_NMI   = 4'd1;
    localparam logic [3:0] SRC_SWI   = 4'd2;
    localparam logic [3:0] SRC_IRQ1  = 4'd3;
    localparam logic [3:0] SRC_ICF   = 4'd4;
    localparam logic [3:0] SRC_OCF   = 4'd5;
    localparam logic [3:0] SRC_TOF   = 4'd6;
    localparam logic [3:0] SRC_SCI   = 4'd7;
    localparam logic [3:0] SRC_TRAP  = 4'd8;

    // Offsets from the lowest vector address. All are even, so the low
    // byte address (vector + 1) never carries out of the vector pair.
    localparam logic [15:0] OFF_RESET = 16'h000E;
    localparam logic [15:0] OFF_NMI   = 16'h000C;
    localparam logic [15:0] OFF_SWI   = 16'h000A;
    localparam logic [15:0] OFF_IRQ1  = 16'h0008;
    localparam logic [15:0] OFF_ICF   = 16'h0006;
    localparam logic [15:0] OFF_OCF   = 16'h0004;
    localparam logic [15:0] OFF_TOF   = 16'h0002;
    localparam logic [15:0] OFF_SCI   = 16'h0000;
    // The trap vector sits one pair below the base.
    localparam logic [15:0] TRAP_BELOW_BASE = 16'h0002;

    // Sequencer state.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_HI   = 3'd1,
        FETCH_HI = 3'd2,
        FETCH_LO = 3'd3,
        DONE     = 3'd4
    } seq_state_t;

    // Request bundle for the priority encoder. The nmi request is carried
    // separately as the edge latch, since only the latch takes part.
    typedef struct packed {
        logic trap;
        logic swi;
        logic irq1;
        logic icf;
        logic ocf;
        logic tof;
        logic sci;
    } int_req_t;

    // High-byte vector address for a given source.
    function automatic logic [15:0] vector_addr(input logic [15:0] base,
                                                input logic [3:0]  src);
        logic [15:0] addr;
        case (src)
            SRC_RESET: addr = base + OFF_RESET;
            SRC_NMI:   addr = base + OFF_NMI;
            SRC_SWI:   addr = base + OFF_SWI;
            SRC_IRQ1:  addr = base + OFF_IRQ1;
            SRC_ICF:   addr = base + OFF_ICF;
            SRC_OCF:   addr = base + OFF_OCF;
            SRC_TOF:   addr = base + OFF_TOF;
            SRC_SCI:   addr = base + OFF_SCI;
            SRC_TRAP:  addr = base - TRAP_BELOW_BASE;
            default:   addr = base + OFF_RESET;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/vector_sequencer_6801_int_priority.sv
// Combinational 6801 interrupt priority encoder. Also used by the core's
// WAI logic, so it carries no state and no notion of the sequencer's busy.
// Order: trap > nmi > swi > irq1 > icf > ocf > tof > sci. Maskable sources
// (irq1, icf, ocf, tof, sci) are ignored while mask_i is set.
module int_priority_6801
    import vector_sequencer_6801_pkg::*;
(
    input  int_req_t   req_i,
    input  logic       mask_i,
    input  logic       nmi_latch_i,
    output logic       pending_o,
    output logic [3:0] winner_o
);

    logic maskable_any;

    // Pending flag and winning source by fixed priority.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch; a path that leaves one unassigned infers a latch.
        winner_o     = SRC_RESET;
        maskable_any = (req_i.irq1 | req_i.icf | req_i.ocf | req_i.tof | req_i.sci) & ~mask_i;
        pending_o    = req_i.trap | nmi_latch_i | req_i.swi | maskable_any;

        if (req_i.trap) begin
            winner_o = SRC_TRAP;
        end else if (nmi_latch_i) begin
            winner_o = SRC_NMI;
        end else if (req_i.swi) begin
            winner_o = SRC_SWI;
        end else if (!mask_i && req_i.irq1) begin
            winner_o = SRC_IRQ1;
        end else if (!mask_i && req_i.icf) begin
            winner_o = SRC_ICF;
        end else if (!mask_i && req_i.ocf) begin
            winner_o = SRC_OCF;
        end else if (!mask_i && req_i.tof) begin
            winner_o = SRC_TOF;
        end else if (!mask_i && req_i.sci) begin
            winner_o = SRC_SCI;
        end
    end

endmodule

// File: rtl/vector_sequencer_6801.sv
// Interrupt/reset vector sequencer for the 6801 core.
// Captures reset and interrupt requests, picks one by fixed priority and,
// once the core grants it with take, owns the pc control mux to load PC
// from the vector pair: high byte first, then low byte.
// Optional feature: define VEC_SEQ_TRAP_EN to add the trap_req input
// (illegal-opcode trap, vector VEC_BASE-2, source code 8).
module vector_sequencer_6801
    import vector_sequencer_6801_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = 16'hFFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mask,
    input  logic        nmi,
    input  logic        swi_req,
    input  logic        irq1,
    input  logic        icf_irq,
    input  logic        ocf_irq,
    input  logic        tof_irq,
    input  logic        sci_irq,
`ifdef VEC_SEQ_TRAP_EN
    input  logic        trap_req,
`endif
    input  logic        take,
    input  logic        mem_ready,
    output logic        int_pending,
    output logic        own_pc,
    output pc_type      pc_ctrl,
    output logic [15:0] vec_addr,
    output logic        mem_rd,
    output logic        busy,
    output logic        vec_done,
    output logic [3:0]  vec_src
);

    seq_state_t  state_q, state_d;
    logic [3:0]  vec_src_q, vec_src_d;
    logic        nmi_latch_q, nmi_latch_d;
    logic        nmi_prev_q;

    int_req_t    req;
    logic        pend_raw;
    logic [3:0]  winner;
    logic        nmi_edge;
    logic        nmi_serviced;
    logic [15:0] vec_hi_addr;

    // Request bundle; without the trap option the trap slot is held low so
    // source code 8 can never win.
    always_comb begin
        req.swi  = swi_req;
        req.irq1 = irq1;
        req.icf  = icf_irq;
        req.ocf  = ocf_irq;
        req.tof  = tof_irq;
        req.sci  = sci_irq;
`ifdef VEC_SEQ_TRAP_EN
        req.trap = trap_req;
`else
        req.trap = 1'b0;
`endif
    end

    int_priority_6801 u_int_priority (
        .req_i       (req),
        .mask_i      (i_mask),
        .nmi_latch_i (nmi_latch_q),
        .pending_o   (pend_raw),
        .winner_o    (winner)
    );

    assign nmi_edge     = nmi & ~nmi_prev_q;
    assign nmi_serviced = (state_q == DONE) && (vec_src_q == SRC_NMI);
    assign vec_hi_addr  = vector_addr(VEC_BASE, vec_src_q);

    // Sequencer state, serviced source, nmi edge detector and nmi latch.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= RST_HI;
            vec_src_q   <= SRC_RESET;
            nmi_latch_q <= 1'b0;
            nmi_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_src_q   <= vec_src_d;
            nmi_latch_q <= nmi_latch_d;
            nmi_prev_q  <= nmi;
        end
    end

    // Nmi latch: a fresh edge sets it, completing an nmi fetch clears it,
    // and an edge in that same DONE cycle keeps it set.
    always_comb begin
        nmi_latch_d = nmi_edge | (nmi_latch_q & ~nmi_serviced);
    end

    // Next state; the winning source is captured only on the grant, so later
    // request changes cannot disturb a fetch in progress.
    always_comb begin
        state_d   = state_q;
        vec_src_d = vec_src_q;
        case (state_q)
            IDLE: begin
                if (take && pend_raw) begin
                    state_d   = FETCH_HI;
                    vec_src_d = winner;
                end
            end
            RST_HI, FETCH_HI: begin
                if (mem_ready) begin
                    state_d = FETCH_LO;
                end
            end
            FETCH_LO: begin
                if (mem_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; the pull operations follow
    // mem_ready in the same cycle so PC captures the bus data directly.
    always_comb begin
        own_pc   = 1'b0;
        pc_ctrl  = latch_pc;
        mem_rd   = 1'b0;
        vec_addr = vec_hi_addr;
        busy     = (state_q != IDLE);
        vec_done = 1'b0;
        case (state_q)
            RST_HI, FETCH_HI: begin
                own_pc = 1'b1;
                mem_rd = 1'b1;
                if (mem_ready) begin
                    pc_ctrl = pull_hi_pc;
                end
            end
            FETCH_LO: begin
                own_pc   = 1'b1;
                mem_rd   = 1'b1;
                vec_addr = vec_hi_addr + 16'd1;
                if (mem_ready) begin
                    pc_ctrl = pull_lo_pc;
                end
            end
            DONE: begin
                vec_done = 1'b1;
            end
            default: begin
                own_pc = 1'b0;
            end
        endcase
    end

    assign int_pending = pend_raw & ~busy;
    assign vec_src     = vec_src_q;

endmodule

// File: tb/tb_vector_sequencer_6801.sv
// Self-checking bench for vector_sequencer_6801. Expected vector fetches
// are queued when a fetch is started and compared when the sequencer
// pulls the high byte, pulls the low byte and signals vec_done.
// Build with VEC_SEQ_TRAP_EN defined to cover the trap source as well.
`timescale 1ns/1ps
module tb_vector_sequencer_6801;
    import vector_sequencer_6801_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mask;
    logic        nmi;
    logic        swi_req;
    logic        irq1;
    logic        icf_irq;
    logic        ocf_irq;
    logic        tof_irq;
    logic        sci_irq;
    logic        trap_req;
    logic        take;
    logic        mem_ready;
    logic        int_pending;
    logic        own_pc;
    pc_type      pc_ctrl;
    logic [15:0] vec_addr;
    logic        mem_rd;
    logic        busy;
    logic        vec_done;
    logic [3:0]  vec_src;

    typedef struct {
        logic [3:0]  src;
        logic [15:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vector_sequencer_6801 #(.VEC_BASE(16'hFFF0)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mask      (i_mask),
        .nmi         (nmi),
        .swi_req     (swi_req),
        .irq1        (irq1),
        .icf_irq     (icf_irq),
        .ocf_irq     (ocf_irq),
        .tof_irq     (tof_irq),
        .sci_irq     (sci_irq),
`ifdef VEC_SEQ_TRAP_EN
        .trap_req    (trap_req),
`endif
        .take        (take),
        .mem_ready   (mem_ready),
        .int_pending (int_pending),
        .own_pc      (own_pc),
        .pc_ctrl     (pc_ctrl),
        .vec_addr    (vec_addr),
        .mem_rd      (mem_rd),
        .busy        (busy),
        .vec_done    (vec_done),
        .vec_src     (vec_src)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] src, input logic [15:0] addr);
        exp_t e;
        e.src  = src;
        e.addr = addr;
        sb_q.push_back(e);
    endtask

    // Grant one fetch from IDLE and require vec_done three cycles after take.
    task automatic take_and_wait(input string tag);
        int n;
        take = 1'b1;
        tick();
        take = 1'b0;
        n = 1;
        while (!vec_done && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 3);
        tick();
        check({tag, "_done_pulse"}, {31'd0, vec_done}, 0);
        check({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    // From the first RST_HI cycle after release, vec_done follows two edges later.
    task automatic wait_reset_fetch(input string tag);
        int n;
        n = 0;
        while (!vec_done && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 2);
        tick();
        check({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (pc_ctrl == pull_hi_pc || pc_ctrl == pull_lo_pc || vec_done) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_activity", sb_q.size(), 1);
            end else if (pc_ctrl == pull_hi_pc) begin
                check("sb_hi_addr", {16'd0, vec_addr}, {16'd0, sb_q[0].addr});
                check("sb_hi_rd", {31'd0, mem_rd}, 1);
            end else if (pc_ctrl == pull_lo_pc) begin
                check("sb_lo_addr", {16'd0, vec_addr}, {16'd0, sb_q[0].addr + 16'd1});
                check("sb_lo_own", {31'd0, own_pc}, 1);
            end else begin
                check("sb_src", {28'd0, vec_src}, {28'd0, sb_q[0].src});
                check("sb_done_own", {31'd0, own_pc}, 0);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_mask = 1'b0; nmi = 1'b0; swi_req = 1'b0;
        irq1 = 1'b0; icf_irq = 1'b0; ocf_irq = 1'b0; tof_irq = 1'b0;
        sci_irq = 1'b0; trap_req = 1'b0; take = 1'b0; mem_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 1);
        check("rst_addr", {16'd0, vec_addr}, 32'hFFFE);
        check("rst_src", {28'd0, vec_src}, 0);
        check("rst_done", {31'd0, vec_done}, 0);
        check("rst_pc_latch", 32'(pc_ctrl), 32'(latch_pc));
        check("rst_mem_rd", {31'd0, mem_rd}, 1);
        check("rst_pending", {31'd0, int_pending}, 0);

        // Reset fetch runs without take.
        push(SRC_RESET, 16'hFFFE);
        rst = 1'b0;
        mem_ready = 1'b1;
        wait_reset_fetch("reset_fetch");
        check("post_reset_pending", {31'd0, int_pending}, 0);

        // Masked irq1 with take: ignored.
        irq1 = 1'b1;
        i_mask = 1'b1;
        #1;
        check("masked_pending", {31'd0, int_pending}, 0);
        take = 1'b1;
        tick();
        take = 1'b0;
        check("masked_no_fetch", {31'd0, busy}, 0);
        i_mask = 1'b0;
        #1;
        check("unmasked_pending", {31'd0, int_pending}, 1);
        push(SRC_IRQ1, 16'hFFF8);
        take_and_wait("irq1");
        irq1 = 1'b0;

        // nmi pulse plus irq1: nmi first, irq1 on the next take.
        nmi = 1'b1;
        tick();
        nmi = 1'b0;
        irq1 = 1'b1;
        #1;
        check("nmi_pending", {31'd0, int_pending}, 1);
        push(SRC_NMI, 16'hFFFC);
        take_and_wait("nmi_vs_irq1");
        push(SRC_IRQ1, 16'hFFF8);
        take_and_wait("irq1_after_nmi");
        irq1 = 1'b0;
        #1;
        check("nmi_latch_cleared", {31'd0, int_pending}, 0);

        // swi with a three-cycle stall; an nmi edge arrives mid-fetch and a
        // higher-priority request must not disturb the latched source.
        mem_ready = 1'b0;
        swi_req = 1'b1;
        push(SRC_SWI, 16'hFFFA);
        take = 1'b1;
        tick();
        take = 1'b0;
        swi_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_pc_latch", 32'(pc_ctrl), 32'(latch_pc));
            check("stall_mem_rd", {31'd0, mem_rd}, 1);
            check("stall_addr", {16'd0, vec_addr}, 32'hFFFA);
            check("stall_pending_busy", {31'd0, int_pending}, 0);
            if (i == 0) nmi = 1'b1;
            if (i == 1) nmi = 1'b0;
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("stall_release_pull_hi", 32'(pc_ctrl), 32'(pull_hi_pc));
        tick();
        check("stall_src_held", {28'd0, vec_src}, {28'd0, SRC_SWI});
        tick();
        check("stall_done", {31'd0, vec_done}, 1);
        tick();
        check("mid_fetch_nmi_kept", {31'd0, int_pending}, 1);
        push(SRC_NMI, 16'hFFFC);
        take_and_wait("nmi_after_swi");

        // nmi edge in the DONE cycle of an nmi fetch: set wins over clear.
        nmi = 1'b1;
        tick();
        nmi = 1'b0;
        push(SRC_NMI, 16'hFFFC);
        take = 1'b1;
        tick();
        take = 1'b0;
        tick();
        tick();
        check("nmi_done_cycle", {31'd0, vec_done}, 1);
        nmi = 1'b1;
        tick();
        nmi = 1'b0;
        check("nmi_set_wins", {31'd0, int_pending}, 1);
        push(SRC_NMI, 16'hFFFC);
        take_and_wait("nmi_rearmed");
        #1;
        check("nmi_rearm_cleared", {31'd0, int_pending}, 0);

        // Reset during FETCH_LO of a tof fetch, with an nmi edge latched.
        tof_irq = 1'b1;
        push(SRC_TOF, 16'hFFF2);
        take = 1'b1;
        tick();
        take = 1'b0;
        tof_irq = 1'b0;
        nmi = 1'b1;
        tick();
        nmi = 1'b0;
        check("tof_in_fetch_lo", 32'(pc_ctrl), 32'(pull_lo_pc));
        rst = 1'b1;
        tick();
        sb_q.delete();
        push(SRC_RESET, 16'hFFFE);
        check("abort_busy", {31'd0, busy}, 1);
        check("abort_addr", {16'd0, vec_addr}, 32'hFFFE);
        check("abort_src", {28'd0, vec_src}, 0);
        check("abort_own", {31'd0, own_pc}, 1);
        check("abort_done", {31'd0, vec_done}, 0);
        rst = 1'b0;
        wait_reset_fetch("abort_reset_fetch");
        check("abort_nmi_latch_cleared", {31'd0, int_pending}, 0);

`ifdef VEC_SEQ_TRAP_EN
        // trap beats nmi and swi; nmi then swi follow.
        trap_req = 1'b1;
        swi_req = 1'b1;
        nmi = 1'b1;
        tick();
        nmi = 1'b0;
        push(SRC_TRAP, 16'hFFEE);
        take_and_wait("trap");
        trap_req = 1'b0;
        push(SRC_NMI, 16'hFFFC);
        take_and_wait("nmi_after_trap");
        push(SRC_SWI, 16'hFFFA);
        take_and_wait("swi_after_trap");
        swi_req = 1'b0;
`endif

        tick();
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
